// File: rtl/axis_pattern_gen_pkg.sv
// Shared definitions for the AXI4-Stream pattern generator slice.
//  - PG_MODE_* : encodings of the 2-bit data mode input
//  - pg_state_t: generator FSM states
//  - cnt_width : counter width able to hold 0..n-1 (never narrower than 1 bit)
package vd_pkg;

  localparam logic [1:0] PG_MODE_CNT   = 2'd0;  // free-running counter
  localparam logic [1:0] PG_MODE_FCNT  = 2'd1;  // counter reloaded at each SOF
  localparam logic [1:0] PG_MODE_XY    = 2'd2;  // {y, x} raster coordinates
  localparam logic [1:0] PG_MODE_CONST = 2'd3;  // constant seed value

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } pg_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream video bus (tdata/tvalid/tready/tuser=SOF/tlast=EOL).
//  master: drives tdata, tvalid, tuser, tlast; samples tready
//  slave : samples tdata, tvalid, tuser, tlast; drives tready
interface axis_pattern_gen_if #(
  parameter int DATA_W = 32
) ();
  import vd_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/axis_pattern_gen_xy_cnt.sv
// Raster position counter for one frame of H_ACTIVE x V_ACTIVE beats.
//  aclk, areset : clock and synchronous active-high reset
//  clear        : force position back to (0,0) (frame start)
//  advance      : step to the next beat (one accepted transfer)
//  x, y         : current column / line
//  sof/eol/eof  : current beat is first of frame / last of line / last of frame
// The position wraps to (0,0) after the last beat of the frame.
module axis_pattern_xy_cnt
  import vd_pkg::*;
#(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 8,
  parameter int XW       = cnt_width(H_ACTIVE),
  parameter int YW       = cnt_width(V_ACTIVE)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;

  assign sof = (x_reg == '0) && (y_reg == '0);
  assign eol = (x_reg == XW'(H_ACTIVE - 1));
  assign eof = eol && (y_reg == YW'(V_ACTIVE - 1));
  assign x   = x_reg;
  assign y   = y_reg;

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (advance) begin
      if (eol) begin
        x_reg <= '0;
        y_reg <= eof ? '0 : y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream video pattern source: frames of H_ACTIVE x V_ACTIVE beats,
// SOF on tuser, EOL on tlast, with tready backpressure and four data modes.
//  aclk, areset : clock and synchronous active-high reset
//  enable       : level; high = keep generating frames
//  mode, seed   : data mode and start/constant value, latched at frame start
//  m_axis       : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//  frame_done   : one-cycle pulse after the last beat of a frame is accepted
//  frame_cnt    : completed frame count, wraps at 2^16
// All stream outputs are decoded from registered state only, so they stay
// stable while a beat is stalled and only move after an accepted transfer.
module axis_pattern_gen
  import vd_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int H_ACTIVE    = 16,
  parameter int V_ACTIVE    = 8,
  parameter int START_DELAY = 25,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  axis_pattern_gen_if.master m_axis,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int XW = cnt_width(H_ACTIVE);
  localparam int YW = cnt_width(V_ACTIVE);
  localparam int DW = cnt_width(START_DELAY);
  localparam int GW = cnt_width((GAP_CYCLES > 0) ? GAP_CYCLES : 1);
  localparam int HW = DATA_W / 2;

  pg_state_t         state_reg, state_next;
  logic [DW-1:0]     delay_reg, delay_next;
  logic [GW-1:0]     gap_reg, gap_next;
  logic [1:0]        mode_reg, mode_next;
  logic [DATA_W-1:0] seed_reg, seed_next;
  logic [DATA_W-1:0] data_cnt_reg, data_cnt_next;
  logic              seeded_reg, seeded_next;   // a frame has started since reset
  logic              frame_done_reg, frame_done_next;
  logic [15:0]       frame_cnt_reg, frame_cnt_next;

  logic              start_frame;
  logic              xfer;
  logic [XW-1:0]     pos_x;
  logic [YW-1:0]     pos_y;
  logic              pos_sof, pos_eol, pos_eof;
  logic [DATA_W-1:0] xy_word;
  logic [DATA_W-1:0] pix_data;

  assign xfer = (state_reg == STREAM) && m_axis.tready;

  axis_pattern_xy_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_xy_cnt (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (start_frame),
    .advance (xfer),
    .x       (pos_x),
    .y       (pos_y),
    .sof     (pos_sof),
    .eol     (pos_eol),
    .eof     (pos_eof)
  );

  // {y, x} word: each coordinate zero-extended into its DATA_W/2 half.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_xy
    if (gi < HW) begin : g_lo
      if (gi < XW) begin : g_x
        assign xy_word[gi] = pos_x[gi];
      end else begin : g_xz
        assign xy_word[gi] = 1'b0;
      end
    end else begin : g_hi
      if ((gi - HW) < YW && (gi - HW) < HW) begin : g_y
        assign xy_word[gi] = pos_y[gi-HW];
      end else begin : g_yz
        assign xy_word[gi] = 1'b0;
      end
    end
  end

  always_comb begin
    case (mode_reg)
      PG_MODE_XY:    pix_data = xy_word;
      PG_MODE_CONST: pix_data = seed_reg;
      default:       pix_data = data_cnt_reg;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    delay_next      = delay_reg;
    gap_next        = gap_reg;
    mode_next       = mode_reg;
    seed_next       = seed_reg;
    data_cnt_next   = data_cnt_reg;
    seeded_next     = seeded_reg;
    frame_done_next = 1'b0;
    frame_cnt_next  = frame_cnt_reg;
    start_frame     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = WAIT;
          delay_next = DW'(START_DELAY - 1);
        end
      end
      WAIT: begin
        if (!enable)               state_next  = IDLE;
        else if (delay_reg == '0)  start_frame = 1'b1;
        else                       delay_next  = delay_reg - DW'(1);
      end
      STREAM: begin
        // enable is only consulted once the frame is complete.
        if (xfer && pos_eof) begin
          frame_done_next = 1'b1;
          frame_cnt_next  = frame_cnt_reg + 16'd1;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            gap_next   = GW'(GAP_CYCLES - 1);
          end else if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_reg != '0)  gap_next    = gap_reg - GW'(1);
        else if (enable)    start_frame = 1'b1;
        else                state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (xfer) data_cnt_next = data_cnt_reg + DATA_W'(1);

    // Frame start overrides the increment: mode 1 always reloads, and the
    // free counter takes the seed only for the first frame after reset.
    if (start_frame) begin
      state_next  = STREAM;
      mode_next   = mode;
      seed_next   = seed;
      seeded_next = 1'b1;
      if (mode == PG_MODE_FCNT || !seeded_reg) data_cnt_next = seed;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      delay_reg      <= '0;
      gap_reg        <= '0;
      mode_reg       <= '0;
      seed_reg       <= '0;
      data_cnt_reg   <= '0;
      seeded_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      delay_reg      <= delay_next;
      gap_reg        <= gap_next;
      mode_reg       <= mode_next;
      seed_reg       <= seed_next;
      data_cnt_reg   <= data_cnt_next;
      seeded_reg     <= seeded_next;
      frame_done_reg <= frame_done_next;
      frame_cnt_reg  <= frame_cnt_next;
    end
  end

  // Outputs are gated by STREAM so every output reads 0 outside a frame.
  assign m_axis.tvalid = (state_reg == STREAM);
  assign m_axis.tuser  = (state_reg == STREAM) && pos_sof;
  assign m_axis.tlast  = (state_reg == STREAM) && pos_eol;
  assign m_axis.tdata  = (state_reg == STREAM) ? pix_data : '0;
  assign frame_done    = frame_done_reg;
  assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen (default geometry 16x8, delay 25,
// gap 4). A beat-index reference model predicts every output cycle by cycle;
// a constant table adds independent probe checks on chosen beats.
module tb_axis_pattern_gen;
  import vd_pkg::*;

  localparam int DW  = 32;
  localparam int H   = 16;
  localparam int V   = 8;
  localparam int SD  = 25;
  localparam int GAP = 4;
  localparam int NB  = H * V;

  logic          aclk   = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode   = 2'd0;
  logic [DW-1:0] seed   = '0;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  axis_pattern_gen_if #(.DATA_W(DW)) m_if ();

  axis_pattern_gen #(
    .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .START_DELAY(SD), .GAP_CYCLES(GAP)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .mode       (mode),
    .seed       (seed),
    .m_axis     (m_if),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 aclk = ~aclk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          frames_model = 0;
  logic [31:0] free_model = '0;
  bit          fresh = 1'b1;

  typedef struct {
    logic [1:0]  md;
    logic [31:0] sd;
    int          pct;
    int          probe_k;
    logic [33:0] probe_exp;   // {tuser, tlast, tdata}
    logic [31:0] last_exp;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: what beat k of a frame must carry, from the mode rules.
  function automatic logic [31:0] exp_data(input logic [1:0] md, input logic [31:0] sd,
                                           input int k, input logic [31:0] fbase);
    int x, y;
    x = k % H;
    y = k / H;
    case (md)
      2'd0:    return fbase + 32'(k);
      2'd1:    return sd + 32'(k);
      2'd2:    return (32'(y) << 16) | 32'(x);
      default: return sd;
    endcase
  endfunction

  // Ticks until tvalid is seen; compares the count against exp_cnt.
  task automatic wait_frame(input int exp_cnt, input string nm);
    int c;
    c = 0;
    m_if.tready = 1'b0;
    while (m_if.tvalid !== 1'b1 && c < 2000) begin
      tick();
      c++;
    end
    check(nm, 64'(c), 64'(exp_cnt));
  endtask

  // Streams beats 0..stop-1 of a frame, checking every cycle (stalls too).
  task automatic stream_frame(input logic [1:0] md, input logic [31:0] sd, input int pct,
                              input int stop, input int drop_at, input int probe_k,
                              input string tag, output logic [33:0] probe,
                              output logic [31:0] last_data);
    int          k, guard;
    bit          rdy;
    logic [51:0] act_v, exp_v;
    logic [31:0] ed;
    k = 0;
    guard = 0;
    probe = '0;
    last_data = '0;
    if (md == 2'd0 && fresh) free_model = sd;
    fresh = 1'b0;
    while (k < stop && guard < 20000) begin
      guard++;
      if (k == drop_at) enable = 1'b0;
      if (k == 1) begin
        mode = 2'($urandom);   // must be ignored until the next frame
        seed = $urandom;
      end
      ed    = exp_data(md, sd, k, free_model);
      exp_v = {frames_model[15:0], 1'b0, 1'b1, (k == 0), ((k % H) == H - 1), ed};
      act_v = {frame_cnt, frame_done, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata};
      check($sformatf("%s_beat%0d", tag, k), 64'(act_v), 64'(exp_v));
      rdy = (int'($urandom_range(0, 99)) < pct);
      m_if.tready = rdy;
      if (rdy && k == probe_k) probe = {m_if.tuser, m_if.tlast, m_if.tdata};
      if (rdy) last_data = m_if.tdata;
      tick();
      if (rdy) k++;
    end
    m_if.tready = 1'b0;
    if (guard >= 20000) check({tag, "_timeout"}, 64'(k), 64'(stop));
    if (stop == NB) begin
      frames_model++;
      if (md == 2'd0) free_model = free_model + 32'(NB);
      check({tag, "_end"}, 64'({frame_cnt, frame_done, m_if.tvalid}),
            64'({frames_model[15:0], 1'b1, 1'b0}));
    end
    $display("frame %s mode=%0d seed=%h beats=%0d cycles=%0d", tag, md, sd, k, guard);
  endtask

  initial begin
    logic [33:0] probe;
    logic [31:0] last_data;
    logic [1:0]  md;
    logic [31:0] sd;
    int          cnt;

    vecs[0] = '{2'd2, 32'h0,         100, 53,  {2'b00, 32'h0003_0005}, 32'h0007_000F};
    vecs[1] = '{2'd1, 32'h100,       50,  0,   {2'b10, 32'h0000_0100}, 32'h0000_017F};
    vecs[2] = '{2'd1, 32'h100,       50,  15,  {2'b01, 32'h0000_010F}, 32'h0000_017F};
    vecs[3] = '{2'd3, 32'hCAFE_F00D, 70,  77,  {2'b00, 32'hCAFE_F00D}, 32'hCAFE_F00D};
    vecs[4] = '{2'd2, 32'h0,         30,  127, {2'b01, 32'h0007_000F}, 32'h0007_000F};

    m_if.tready = 1'b0;

    // Reset state
    areset = 1'b1;
    repeat (3) tick();
    check("reset_state", 64'({frame_cnt, frame_done, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}), 64'(0));
    areset = 1'b0;
    tick();

    // Test 1: mode 0, seed 0, continuous ready, two frames
    mode = 2'd0; seed = 32'h0; enable = 1'b1;
    tick();
    wait_frame(SD, "t1_latency");
    stream_frame(2'd0, 32'h0, 100, NB, -1, 127, "t1f0", probe, last_data);
    check("t1f0_last", 64'(probe), 64'({2'b01, 32'd127}));
    mode = 2'd0; seed = 32'hDEAD_0000;   // not reloaded: free counter keeps running
    wait_frame(GAP, "t1_gap");
    stream_frame(2'd0, 32'hDEAD_0000, 100, NB, -1, 0, "t1f1", probe, last_data);
    check("t1f1_first", 64'(probe), 64'({2'b10, 32'd128}));

    // Table-driven frames with constant probes
    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].md;
      seed = vecs[i].sd;
      wait_frame(GAP, $sformatf("tbl%0d_gap", i));
      stream_frame(vecs[i].md, vecs[i].sd, vecs[i].pct, NB, -1, vecs[i].probe_k,
                   $sformatf("tbl%0d", i), probe, last_data);
      check($sformatf("tbl%0d_probe", i), 64'(probe), 64'(vecs[i].probe_exp));
      check($sformatf("tbl%0d_lastbeat", i), 64'(last_data), 64'(vecs[i].last_exp));
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 4; i++) begin
      md = 2'($urandom_range(1, 3));
      sd = $urandom;
      mode = md;
      seed = sd;
      wait_frame(GAP, $sformatf("rnd%0d_gap", i));
      stream_frame(md, sd, int'($urandom_range(20, 100)), NB, -1, -1,
                   $sformatf("rnd%0d", i), probe, last_data);
    end

    // Test 4: enable dropped at beat 40; frame completes, then stays idle
    mode = 2'd1; seed = 32'h2000;
    wait_frame(GAP, "t4_gap");
    stream_frame(2'd1, 32'h2000, 60, NB, 40, -1, "t4", probe, last_data);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_if.tvalid) cnt++;
      tick();
    end
    check("t4_idle_valid", 64'(cnt), 64'(0));

    // Test 5: reset at beat 60, then a fresh frame from the seed
    mode = 2'd1; seed = 32'h300; enable = 1'b1;
    tick();
    wait_frame(SD, "t5_latency0");
    stream_frame(2'd1, 32'h300, 100, 60, -1, -1, "t5a", probe, last_data);
    areset = 1'b1;
    tick();
    check("t5_reset", 64'({m_if.tvalid, frame_done, frame_cnt}), 64'(0));
    frames_model = 0;
    fresh = 1'b1;
    areset = 1'b0;
    enable = 1'b0;
    tick();
    mode = 2'd0; seed = 32'h4000; enable = 1'b1;
    tick();
    wait_frame(SD, "t5_latency1");
    stream_frame(2'd0, 32'h4000, 80, NB, -1, 0, "t5b", probe, last_data);
    check("t5b_first", 64'(probe), 64'({2'b10, 32'h4000}));

    // Test 6: free counter wrap 0xFFFFFFFF -> 0
    enable = 1'b0;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    frames_model = 0;
    fresh = 1'b1;
    mode = 2'd0; seed = 32'hFFFF_FFF0; enable = 1'b1;
    tick();
    wait_frame(SD, "t6_latency");
    stream_frame(2'd0, 32'hFFFF_FFF0, 100, NB, -1, 16, "t6", probe, last_data);
    check("t6_wrapped", 64'(probe), 64'({2'b00, 32'h0000_0000}));
    check("t6_lastbeat", 64'(last_data), 64'(32'h0000_006F));
    enable = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
